seq_bit_serializer: RTL

Parallel-to-serial front end for the 1011 sequence detector. Accepts WIDTH-bit words over a valid/ready handshake, buffers one word in a holding register, and emits one bit per clock on `ser_bit`, which drives the detector's `inp_bit` directly. Back-to-back words produce a gap-free bitstream; when idle, the output is forced to 0 so the detector sees no spurious ones.

---
 rtl/seq_bit_serializer_if.sv | 32 +++
 rtl/seq_bit_serializer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/seq_bit_serializer_if.sv
// +----------------------------------------------------------------------------+
// | seq_bit_serializer_if                                                      |
// | Word handshake and serial-output bundle for seq_bit_serializer.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface seq_bit_serializer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_bit;
  logic             ser_valid;
  logic             word_done;
  logic             busy;
  logic [CNT_W-1:0] words_sent;

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_bit, ser_valid, word_done, busy, words_sent
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_bit, ser_valid, word_done, busy, words_sent
  );
endinterface

`default_nettype wire

// File: rtl/seq_bit_serializer.sv
// +----------------------------------------------------------------------------+
// | seq_bit_serializer                                                         |
// | Parallel-to-serial front end feeding the 1011 detector, with one-word      |
// | holding buffer for gap-free streaming. Macro SEQ_SER_LSB_FIRST_EN selects  |
// | LSB-first order (default MSB-first).                                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_bit_serializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  wire logic           clk,
  input  wire logic           reset_n,
  seq_bit_serializer_if.slave bus
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           st, st_nxt;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full, hold_full_nxt;
  logic [WIDTH-1:0] shift_data, shift_nxt, shift_adv;
  logic [BW-1:0]    bit_idx, bit_nxt;
  logic [CNT_W-1:0] words_cnt;
  logic             accept, load, at_last, out_bit;

  assign accept  = bus.in_valid && !hold_full;
  assign at_last = (bit_idx == LAST_IDX);
  assign load    = hold_full && ((st == IDLE) || ((st == SHIFT) && at_last));

`ifdef SEQ_SER_LSB_FIRST_EN
  assign shift_adv = {1'b0, shift_data[WIDTH-1:1]};
  assign out_bit   = shift_data[0];
`else
  assign shift_adv = {shift_data[WIDTH-2:0], 1'b0};
  assign out_bit   = shift_data[WIDTH-1];
`endif

  always_comb begin
    st_nxt        = st;
    bit_nxt       = bit_idx;
    shift_nxt     = shift_data;
    hold_full_nxt = hold_full;

    if (accept) begin
      hold_full_nxt = 1'b1;
    end else if (load) begin
      hold_full_nxt = 1'b0;
    end

    case (st)
      IDLE: begin
        if (load) begin
          st_nxt    = SHIFT;
          bit_nxt   = '0;
          shift_nxt = hold_data;
        end
      end
      SHIFT: begin
        if (!at_last) begin
          bit_nxt   = bit_idx + 1'b1;
          shift_nxt = shift_adv;
        end else if (load) begin
          // Next word follows the last bit directly: no idle cycle.
          bit_nxt   = '0;
          shift_nxt = hold_data;
        end else begin
          st_nxt  = IDLE;
          bit_nxt = '0;
        end
      end
      default: begin
        st_nxt  = IDLE;
        bit_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st         <= IDLE;
      bit_idx    <= '0;
      shift_data <= '0;
      hold_full  <= 1'b0;
      hold_data  <= '0;
    end else begin
      st         <= st_nxt;
      bit_idx    <= bit_nxt;
      shift_data <= shift_nxt;
      hold_full  <= hold_full_nxt;
      if (accept) begin
        hold_data <= bus.in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      words_cnt <= '0;
    end else if (bus.word_done && (words_cnt != {CNT_W{1'b1}})) begin
      words_cnt <= words_cnt + 1'b1;
    end
  end

  assign bus.in_ready   = !hold_full;
  assign bus.ser_valid  = (st == SHIFT);
  assign bus.ser_bit    = bus.ser_valid && out_bit;
  assign bus.word_done  = bus.ser_valid && at_last;
  assign bus.busy       = bus.ser_valid || hold_full;
  assign bus.words_sent = words_cnt;

endmodule

`default_nettype wire
